// File: rtl/tcb_if.sv
// TCB point-to-point bus: request channel from manager, response/ready from subordinate.
// The manager drives the request (vld..wdt); the subordinate returns rdy, rdt and err.
interface tcb_if #(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8
);
    localparam int BEW = DBW / SLW;
    // siz holds log2 of the transfer size in bytes
    localparam int SZW = (BEW > 1) ? $clog2($clog2(BEW) + 1) : 1;

    logic           vld;
    logic           inc;
    logic           rpt;
    logic           lck;
    logic           ndn;
    logic           wen;
    logic [ABW-1:0] adr;
    logic [SZW-1:0] siz;
    logic [BEW-1:0] ben;
    logic [DBW-1:0] wdt;
    logic [DBW-1:0] rdt;
    logic           err;
    logic           rdy;

    // A request is accepted in the cycle where vld and rdy are both high;
    // the manager holds all request fields stable while vld=1 and rdy=0.
    modport man (
        output vld, inc, rpt, lck, ndn, wen, adr, siz, ben, wdt,
        input  rdt, err, rdy
    );

    modport sub (
        input  vld, inc, rpt, lck, ndn, wen, adr, siz, ben, wdt,
        output rdt, err, rdy
    );
endinterface

// File: rtl/tcb_arbiter_rr.sv
// Round-robin arbiter sharing one TCB subordinate between MPN managers, with
// grant freeze on stalls/locks and DLY-cycle response routing back to the requester.
module tcb_arbiter_rr #(
    parameter int MPN = 2,
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8,
    parameter int DLY = 1,
    localparam int IDW = (MPN > 1) ? $clog2(MPN) : 1
) (
    input  logic           clk,
    input  logic           rst,
    tcb_if.sub             man [MPN],
    tcb_if.man             sub,
    output logic [IDW-1:0] gnt
);
    localparam int BEW = DBW / SLW;
    localparam int SZW = (BEW > 1) ? $clog2($clog2(BEW) + 1) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] sel, sel_nxt;
    logic [IDW-1:0] grant, grant_srch, grant_inc;
    logic           found;

    logic [MPN-1:0] req, lck_v, inc_v, rpt_v, ndn_v, wen_v;
    logic [ABW-1:0] adr_v [MPN];
    logic [SZW-1:0] siz_v [MPN];
    logic [BEW-1:0] ben_v [MPN];
    logic [DBW-1:0] wdt_v [MPN];

    logic           fwd_vld, fwd_lck, fwd_wen, trn;
    logic           rv_o, rw_o;
    logic [IDW-1:0] ri_o;

    for (genvar i = 0; i < MPN; i++) begin : g_man_in
        assign req[i]   = man[i].vld;
        assign lck_v[i] = man[i].lck;
        assign inc_v[i] = man[i].inc;
        assign rpt_v[i] = man[i].rpt;
        assign ndn_v[i] = man[i].ndn;
        assign wen_v[i] = man[i].wen;
        assign adr_v[i] = man[i].adr;
        assign siz_v[i] = man[i].siz;
        assign ben_v[i] = man[i].ben;
        assign wdt_v[i] = man[i].wdt;
    end

    // First requester at or after ptr, wrapping modulo MPN.
    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        grant_srch = ptr;
        for (int k = 0; k < MPN; k++) begin
            idx = (int'(ptr) + k) % MPN;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant_srch = IDW'(idx);
            end
        end
    end

    assign grant     = (state == IDLE) ? grant_srch : sel;
    assign grant_inc = IDW'((int'(grant) + 1) % MPN);

    // Everything facing the bus is gated by rst so reset forces an idle bus.
    assign fwd_vld = rst & req[grant];
    assign fwd_lck = lck_v[grant];
    assign fwd_wen = wen_v[grant];
    assign trn     = fwd_vld & sub.rdy;
    assign gnt     = rst ? grant : '0;

    assign sub.vld = fwd_vld;
    assign sub.inc = inc_v[grant];
    assign sub.rpt = rpt_v[grant];
    assign sub.lck = fwd_lck;
    assign sub.ndn = ndn_v[grant];
    assign sub.wen = fwd_wen;
    assign sub.adr = adr_v[grant];
    assign sub.siz = siz_v[grant];
    assign sub.ben = ben_v[grant];
    assign sub.wdt = wdt_v[grant];

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        if (trn && fwd_lck) begin
            state_nxt = LOCK;
            sel_nxt   = grant;
        end else if (trn) begin
            state_nxt = IDLE;
            ptr_nxt   = grant_inc;
        end else if (state != HOLD && fwd_vld && !sub.rdy) begin
            state_nxt = HOLD;
            sel_nxt   = grant;
        end else if (state == HOLD && !fwd_vld) begin
            // manager withdrew a stalled request; resume arbitration from the same ptr
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

    if (DLY == 0) begin : g_rsp_comb
        assign rv_o = trn & ~fwd_wen;
        assign rw_o = trn & fwd_wen;
        assign ri_o = grant;
    end else begin : g_rsp_pipe
        logic [DLY-1:0] rv_p, rw_p;
        logic [IDW-1:0] ri_p [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rv_p <= '0;
                rw_p <= '0;
                for (int s = 0; s < DLY; s++) ri_p[s] <= '0;
            end else begin
                rv_p[0] <= trn & ~fwd_wen;
                rw_p[0] <= trn & fwd_wen;
                ri_p[0] <= grant;
                for (int s = 1; s < DLY; s++) begin
                    rv_p[s] <= rv_p[s-1];
                    rw_p[s] <= rw_p[s-1];
                    ri_p[s] <= ri_p[s-1];
                end
            end
        end

        assign rv_o = rv_p[DLY-1];
        assign rw_o = rw_p[DLY-1];
        assign ri_o = ri_p[DLY-1];
    end

    for (genvar i = 0; i < MPN; i++) begin : g_man_out
        assign man[i].rdy = rst & sub.rdy & (grant == IDW'(i));
        assign man[i].rdt = (rst & rv_o & (ri_o == IDW'(i))) ? sub.rdt : '0;
        assign man[i].err = rst & (rv_o | rw_o) & (ri_o == IDW'(i)) & sub.err;
    end
endmodule

// File: tb/tb_tcb_arbiter_rr.sv
// Directed bench: two 4-manager arbiters (DLY=1 and DLY=2) share the same manager
// stimulus and sub.rdy; each has its own subordinate response inputs.
module tb_tcb_arbiter_rr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  m_vld = '0;
    logic [3:0]  m_lck = '0;
    logic [3:0]  m_wen = '0;
    logic        sub_rdy = 1'b0;
    logic [31:0] rdt1 = '0, rdt2 = '0;
    logic        err1 = 1'b0, err2 = 1'b0;

    logic [1:0]  gnt1, gnt2;
    logic        sv1, sv2;
    logic [3:0]  rdy1, rdy2, err_o1, err_o2;
    logic [31:0] rdt_o1 [4];
    logic [31:0] rdt_o2 [4];

    tcb_if m1 [4] ();
    tcb_if m2 [4] ();
    tcb_if s1 ();
    tcb_if s2 ();

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign m1[g].vld = m_vld[g];
        assign m1[g].lck = m_lck[g];
        assign m1[g].wen = m_wen[g];
        assign m1[g].inc = 1'b0;
        assign m1[g].rpt = 1'b0;
        assign m1[g].ndn = 1'b0;
        assign m1[g].adr = 32'(g * 4);
        assign m1[g].siz = 2'd2;
        assign m1[g].ben = 4'hf;
        assign m1[g].wdt = 32'(g);
        assign m2[g].vld = m_vld[g];
        assign m2[g].lck = m_lck[g];
        assign m2[g].wen = m_wen[g];
        assign m2[g].inc = 1'b0;
        assign m2[g].rpt = 1'b0;
        assign m2[g].ndn = 1'b0;
        assign m2[g].adr = 32'(g * 4);
        assign m2[g].siz = 2'd2;
        assign m2[g].ben = 4'hf;
        assign m2[g].wdt = 32'(g);
        assign rdy1[g]   = m1[g].rdy;
        assign rdy2[g]   = m2[g].rdy;
        assign err_o1[g] = m1[g].err;
        assign err_o2[g] = m2[g].err;
        assign rdt_o1[g] = m1[g].rdt;
        assign rdt_o2[g] = m2[g].rdt;
    end

    assign s1.rdy = sub_rdy;
    assign s1.rdt = rdt1;
    assign s1.err = err1;
    assign s2.rdy = sub_rdy;
    assign s2.rdt = rdt2;
    assign s2.err = err2;
    assign sv1    = s1.vld;
    assign sv2    = s2.vld;

    tcb_arbiter_rr #(.MPN(4), .ABW(32), .DBW(32), .SLW(8), .DLY(1)) u_d1 (
        .clk (clk),
        .rst (rst),
        .man (m1),
        .sub (s1),
        .gnt (gnt1)
    );

    tcb_arbiter_rr #(.MPN(4), .ABW(32), .DBW(32), .SLW(8), .DLY(2)) u_d2 (
        .clk (clk),
        .rst (rst),
        .man (m2),
        .sub (s2),
        .gnt (gnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset: a requesting manager must not reach the bus
        sub_rdy = 1'b1;
        m_vld   = 4'b0010;
        tick(); tick();
        chk("rst_sv1", 32'(sv1), 0);
        chk("rst_sv2", 32'(sv2), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rdy1", 32'(rdy1), 0);

        // alternating grants 0,2,0,2 with DLY=1 read data routing
        tick(); rst = 1'b1; m_vld = 4'b0101; #1;
        chk("alt_gnt_a", 32'(gnt1), 0);
        chk("alt_rdy_a", 32'(rdy1), 32'b0001);
        chk("alt_sv_a", 32'(sv1), 1);
        tick(); rdt1 = 32'hA0; #1;
        chk("alt_gnt_b", 32'(gnt1), 2);
        chk("alt_rdy_b", 32'(rdy1), 32'b0100);
        chk("alt_rdt0_b", rdt_o1[0], 32'hA0);
        chk("alt_rdt2_b", rdt_o1[2], 0);
        tick(); rdt1 = 32'hA2; #1;
        chk("alt_gnt_c", 32'(gnt1), 0);
        chk("alt_rdt2_c", rdt_o1[2], 32'hA2);
        chk("alt_rdt0_c", rdt_o1[0], 0);
        tick(); rdt1 = 32'hA0; #1;
        chk("alt_gnt_d", 32'(gnt1), 2);
        chk("alt_rdt0_d", rdt_o1[0], 32'hA0);
        tick(); m_vld = 4'b0000; rdt1 = 32'hA2; #1;
        chk("alt_rdt2_e", rdt_o1[2], 32'hA2);
        chk("alt_rdt0_e", rdt_o1[0], 0);
        chk("alt_sv_e", 32'(sv1), 0);

        // stall: grant frozen on manager 1 while manager 3 waits
        tick(); rdt1 = '0; sub_rdy = 1'b0; m_vld = 4'b0010; #1;
        chk("hold_gnt_f", 32'(gnt1), 1);
        chk("hold_sv_f", 32'(sv1), 1);
        chk("hold_rdy_f", 32'(rdy1), 0);
        tick(); m_vld = 4'b1010; #1;
        chk("hold_gnt_g", 32'(gnt1), 1);
        chk("hold_rdy_g", 32'(rdy1), 0);
        tick(); #1;
        chk("hold_gnt_h", 32'(gnt1), 1);
        tick(); sub_rdy = 1'b1; #1;
        chk("hold_gnt_i", 32'(gnt1), 1);
        chk("hold_rdy_i", 32'(rdy1), 32'b0010);
        // ptr=2 now, so manager 3 wins over manager 0
        tick(); m_vld = 4'b1001; #1;
        chk("hold_gnt_j", 32'(gnt1), 3);
        chk("hold_rdy_j", 32'(rdy1), 32'b1000);
        tick(); m_vld = 4'b0001; #1;
        chk("hold_gnt_k", 32'(gnt1), 0);

        // locked sequence from manager 0 blocks manager 1
        tick(); m_vld = 4'b1000; #1;
        chk("lock_gnt_l", 32'(gnt1), 3);
        tick(); m_vld = 4'b0011; m_lck = 4'b0001; #1;
        chk("lock_gnt_m", 32'(gnt1), 0);
        chk("lock_rdy1_m", 32'(rdy1[1]), 0);
        tick(); m_vld = 4'b0010; #1;
        chk("lock_gnt_n", 32'(gnt1), 0);
        chk("lock_sv_n", 32'(sv1), 0);
        chk("lock_rdy1_n", 32'(rdy1[1]), 0);
        tick(); m_vld = 4'b0011; #1;
        chk("lock_rdy_o", 32'(rdy1), 32'b0001);
        tick(); m_vld = 4'b0010; #1;
        chk("lock_gnt_p", 32'(gnt1), 0);
        chk("lock_rdy1_p", 32'(rdy1[1]), 0);
        tick(); m_vld = 4'b0011; m_lck = 4'b0000; #1;
        chk("lock_rdy_q", 32'(rdy1), 32'b0001);
        tick(); m_vld = 4'b0010; #1;
        chk("lock_gnt_r", 32'(gnt1), 1);
        chk("lock_rdy_r", 32'(rdy1), 32'b0010);

        // DLY=2 back-to-back reads, error on the second (manager 1)
        tick(); m_vld = 4'b1000; #1;
        chk("err_gnt_s", 32'(gnt2), 3);
        tick(); m_vld = 4'b0111; #1;
        chk("err_gnt_t", 32'(gnt2), 0);
        tick(); m_vld = 4'b0110; #1;
        chk("err_gnt_u", 32'(gnt2), 1);
        tick(); m_vld = 4'b0100; err2 = 1'b0; #1;
        chk("err_gnt_v", 32'(gnt2), 2);
        chk("err_o_v", 32'(err_o2), 0);
        tick(); m_vld = 4'b0000; err2 = 1'b1; #1;
        chk("err_o_w", 32'(err_o2), 32'b0010);
        tick(); err2 = 1'b0; #1;
        chk("err_o_x", 32'(err_o2), 0);

        // reset between a read transfer and its response
        tick(); m_vld = 4'b0010; #1;
        chk("rsr_gnt_y", 32'(gnt2), 1);
        tick(); rst = 1'b0; m_vld = 4'b0000;
        rdt1 = 32'hFF; err1 = 1'b1; rdt2 = 32'hFF; err2 = 1'b1; #1;
        chk("rsr_rdt2_z", rdt_o2[1], 0);
        chk("rsr_err2_z", 32'(err_o2), 0);
        chk("rsr_rdt1_z", rdt_o1[1], 0);
        chk("rsr_err1_z", 32'(err_o1), 0);
        chk("rsr_sv2_z", 32'(sv2), 0);
        tick(); rst = 1'b1; m_vld = 4'b1010; #1;
        chk("rsr_rdt2_aa", rdt_o2[1], 0);
        chk("rsr_err2_aa", 32'(err_o2), 0);
        chk("rsr_gnt2_aa", 32'(gnt2), 1);
        chk("rsr_gnt1_aa", 32'(gnt1), 1);
        tick(); m_vld = 4'b1000; rdt1 = '0; err1 = 1'b0; rdt2 = '0; err2 = 1'b0; #1;
        chk("rsr_gnt2_ab", 32'(gnt2), 3);
        tick(); m_vld = 4'b0000;
        tick();

        // writes from managers 1 and 3, error on manager 3's write
        tick(); m_vld = 4'b1010; m_wen = 4'b1010; #1;
        chk("wr_gnt_ae", 32'(gnt1), 1);
        tick(); m_vld = 4'b1000; rdt1 = 32'h55; err1 = 1'b0; #1;
        chk("wr_gnt_af", 32'(gnt1), 3);
        chk("wr_rdt1_af", rdt_o1[1], 0);
        chk("wr_err_af", 32'(err_o1), 0);
        tick(); m_vld = 4'b0000; err1 = 1'b1; #1;
        chk("wr_err_ag", 32'(err_o1), 32'b1000);
        chk("wr_rdt3_ag", rdt_o1[3], 0);
        tick(); err1 = 1'b0; rdt2 = 32'h66; err2 = 1'b1; #1;
        chk("wr_err_ah", 32'(err_o1), 0);
        chk("wr_err2_ah", 32'(err_o2), 32'b1000);
        chk("wr_rdt2_ah", rdt_o2[3], 0);
        tick(); rdt1 = '0; rdt2 = '0; err2 = 1'b0; m_wen = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
